// File: rtl/btn_led_seq_ctrl.sv
// -----------------------------------------------------------------------------
// btn_led_seq_ctrl
//   Sequencing controller for the 4-button / 4-LED board resource.
//   Raw buttons are synchronised (2 flops), debounced per bit, and turned into
//   one-cycle press events. A mode state machine then drives the LEDs with a
//   button mirror, a rotating one-hot, a blink, or an up/down counter.
//
// Ports:
//   clk       in  1  system clock, rising edge
//   reset     in  1  asynchronous, active-high reset
//   btn       in  4  raw push buttons, asynchronous to clk
//   led       out 4  registered LED drive
//   mode      out 2  current mode: 00 MIRROR, 01 SHIFT, 10 BLINK, 11 COUNT
//   dir_o     out 1  registered direction flag     (BTN_LED_SEQ_STATUS_EN only)
//   paused_o  out 1  registered pause flag         (BTN_LED_SEQ_STATUS_EN only)
//
// Build option:
//   BTN_LED_SEQ_STATUS_EN  when defined, exposes dir_o and paused_o.
//
// Button roles (highest priority first when pressed together):
//   btn[3] force MIRROR and clear dir/paused, btn[0] advance mode,
//   btn[2] toggle dir, btn[1] toggle paused.
// -----------------------------------------------------------------------------
module btn_led_seq_ctrl #(
  parameter int DEBOUNCE_CYCLES = 4,  // 2..65535
  parameter int TICK_DIV        = 8   // 2..2^24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] btn,
  output logic [3:0] led,
  output logic [1:0] mode
`ifdef BTN_LED_SEQ_STATUS_EN
  ,
  output logic       dir_o,
  output logic       paused_o
`endif
);

  typedef enum logic [1:0] {
    MIRROR = 2'b00,
    SHIFT  = 2'b01,
    BLINK  = 2'b10,
    COUNT  = 2'b11
  } mode_t;

  localparam logic [15:0] DB_LAST   = 16'(DEBOUNCE_CYCLES - 1);
  localparam logic [23:0] TICK_LAST = 24'(TICK_DIV - 1);

  // ---------------------------------------------------------------------------
  // Input conditioning: synchroniser, debounce, press detection
  // ---------------------------------------------------------------------------
  logic [3:0]  r_sync1;
  logic [3:0]  r_sync2;
  logic [3:0]  r_deb;
  logic [3:0]  r_deb_q;
  logic [3:0]  r_press;
  logic [15:0] r_db_cnt [4];

  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours, exactly like the hardware it describes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_deb   <= '0;
      r_deb_q <= '0;
      r_press <= '0;
      for (int i = 0; i < 4; i++) r_db_cnt[i] <= '0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
      r_deb_q <= r_deb;
      // The press pulse is registered, so an event is applied one edge after
      // the debounced level has already reached the MIRROR display.
      r_press <= r_deb & ~r_deb_q;
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          // Counter would reach DEBOUNCE_CYCLES: accept the new level.
          r_deb[i]    <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 16'd1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Mode state machine and pattern generator
  // ---------------------------------------------------------------------------
  mode_t       r_mode;
  mode_t       w_mode_nxt;
  logic [3:0]  r_led;
  logic [3:0]  w_led_nxt;
  logic        r_dir;
  logic        w_dir_nxt;
  logic        r_paused;
  logic        w_paused_nxt;
  logic [23:0] r_presc;
  logic [23:0] w_presc_nxt;
  logic        w_presc_last;
  logic        w_tick;

  assign w_presc_last = (r_presc == TICK_LAST);
  assign w_tick       = w_presc_last && !r_paused;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mode   <= MIRROR;
      r_led    <= '0;
      r_dir    <= 1'b0;
      r_paused <= 1'b0;
      r_presc  <= '0;
    end else begin
      r_mode   <= w_mode_nxt;
      r_led    <= w_led_nxt;
      r_dir    <= w_dir_nxt;
      r_paused <= w_paused_nxt;
      r_presc  <= w_presc_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_mode_nxt   = r_mode;
    w_led_nxt    = r_led;
    w_dir_nxt    = r_dir;
    w_paused_nxt = r_paused;

    if (r_paused)          w_presc_nxt = r_presc;
    else if (w_presc_last) w_presc_nxt = '0;
    else                   w_presc_nxt = r_presc + 24'd1;

    if (r_mode == MIRROR) w_led_nxt = r_deb;

    // Only the highest-priority event is applied; a coincident tick is lost.
    if (r_press[3]) begin
      w_mode_nxt   = MIRROR;
      w_led_nxt    = r_deb;
      w_dir_nxt    = 1'b0;
      w_paused_nxt = 1'b0;
      w_presc_nxt  = '0;
    end else if (r_press[0]) begin
      w_paused_nxt = 1'b0;
      w_presc_nxt  = '0;
      unique case (r_mode)
        MIRROR: begin w_mode_nxt = SHIFT;  w_led_nxt = 4'b0001; end
        SHIFT:  begin w_mode_nxt = BLINK;  w_led_nxt = 4'b1111; end
        BLINK:  begin w_mode_nxt = COUNT;  w_led_nxt = 4'b0000; end
        COUNT:  begin w_mode_nxt = MIRROR; w_led_nxt = r_deb;   end
        default: ;
      endcase
    end else if (r_press[2]) begin
      w_dir_nxt = ~r_dir;
    end else if (r_press[1]) begin
      // Restarting the prescaler on both pause and resume gives a full
      // TICK_DIV interval before the first step after resuming.
      w_paused_nxt = ~r_paused;
      w_presc_nxt  = '0;
    end else if (w_tick) begin
      unique case (r_mode)
        SHIFT:   w_led_nxt = r_dir ? {r_led[0], r_led[3:1]} : {r_led[2:0], r_led[3]};
        BLINK:   w_led_nxt = ~r_led;
        COUNT:   w_led_nxt = r_dir ? r_led - 4'd1 : r_led + 4'd1;
        default: ;  // MIRROR is refreshed from deb above
      endcase
    end
  end

  assign led  = r_led;
  assign mode = r_mode;

`ifdef BTN_LED_SEQ_STATUS_EN
  assign dir_o    = r_dir;
  assign paused_o = r_paused;
`endif

endmodule
